enum_mode_scheduler: RTL and testbench

- Arbitrates N_REQ requesters that compete to change one shared, enum-typed mode register.
- Sequences each accepted change through a grant, settle, (flush) and done handshake.
- The two enum types it uses (mode_t, sched_state_t) are declared in package sched_pkg, which also exports them to consumer modules.
- The two enums have distinct literal prefixes (MODE_*, ST_*), so wildcard import of both into one scope is collision-free.

---
 rtl/enum_mode_scheduler.sv | 151 +++++++++++++++
 tb/tb_enum_mode_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enum_mode_scheduler.sv
// Round-robin arbiter that serialises requests to change one shared enum-typed mode.
// Each accepted change is sequenced through grant, settle, optional flush and done.

package sched_pkg;
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_FLUSH = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_GRANT  = 3'b001,
        ST_SETTLE = 3'b010,
        ST_FLUSH  = 3'b011,
        ST_DONE   = 3'b100
    } sched_state_t;
endpackage

module enum_mode_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [2*N_REQ-1:0]         req_mode,
    output logic [N_REQ-1:0]           req_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output mode_t                      cur_mode,
    output sched_state_t               state_o,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

    sched_state_t      state_q, state_d;
    mode_t             cur_mode_q, cur_mode_d;
    mode_t             pend_mode_q, pend_mode_d;
    logic [IdxW-1:0]   grant_id_q, grant_id_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;

    mode_t             req_mode_arr [N_REQ];
    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_mode_unpack
        assign req_mode_arr[i] = mode_t'(req_mode[2*i +: 2]);
    end

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IdxW'((32'(last_grant_q) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_mode_d   = cur_mode_q;
        pend_mode_d  = pend_mode_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_id_d  = win_idx;
                    pend_mode_d = req_mode_arr[win_idx];
                    req_ready_d = N_REQ'(1) << win_idx;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (pend_mode_q == cur_mode_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CntLoad;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    cur_mode_d = pend_mode_q;
                    state_d    = (pend_mode_q == MODE_FLUSH) ? ST_FLUSH : ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FLUSH: begin
                // Flush is transient: the mode falls back to idle once it has been visible.
                cur_mode_d = MODE_IDLE;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_mode_q   <= MODE_IDLE;
            pend_mode_q  <= MODE_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= LastIdx;
            cnt_q        <= '0;
            req_ready_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_mode_q   <= cur_mode_d;
            pend_mode_q  <= pend_mode_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign grant_id  = grant_id_q;
    assign cur_mode  = cur_mode_q;
    assign state_o   = state_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_enum_mode_scheduler.sv
// Bench for enum_mode_scheduler: table-driven transactions plus multi-cycle corner sequences,
// with ready/done expectations queued at drive time and checked as the DUT produces them.

module tb_enum_mode_scheduler;
    import sched_pkg::*;

    localparam int N = 4;
    localparam int S = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [2*N-1:0]   req_mode;
    logic [N-1:0]     req_ready;
    logic [1:0]       grant_id;
    mode_t            cur_mode;
    sched_state_t     state_o;
    logic             busy;
    logic             done;

    enum_mode_scheduler #(
        .N_REQ         (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .cur_mode  (cur_mode),
        .state_o   (state_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [N-1:0] mask;
        int         id;
        mode_t      mode;
    } exp_t;

    exp_t rdy_q[$];
    exp_t done_q[$];
    exp_t mon_e;

    typedef struct {
        int    id;
        mode_t mode;
        int    lat;
        mode_t fin;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every ready pulse and done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_done_exclusive", 32'((|req_ready) && done), 32'd0);
            if (|req_ready) begin
                if (rdy_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got %b expected none (cycle %0d)", req_ready, cyc);
                end else begin
                    mon_e = rdy_q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("ready_mask", 32'(req_ready), 32'(mon_e.mask));
                    chk("ready_grant_id", 32'(grant_id), 32'(mon_e.id));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("done_grant_id", 32'(grant_id), 32'(mon_e.id));
                    chk("done_cur_mode", 32'(cur_mode), 32'(mon_e.mode));
                end
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sync();
        sync();
        rst = 1'b0;
        sync();
    endtask

    task automatic drive(input int id, input mode_t m);
        req_mode[2*id +: 2] = m;
        req_valid[id] = 1'b1;
    endtask

    task automatic push(input int c, input int id, input mode_t m, input bit is_done);
        exp_t e;
        e.cyc  = c;
        e.mask = N'(1) << id;
        e.id   = id;
        e.mode = m;
        if (is_done) done_q.push_back(e);
        else rdy_q.push_back(e);
    endtask

    // Runs until both queues drain; unless hold is set, requesters drop valid on their
    // ready pulse and scramble their mode to show the latched mode is used.
    task automatic service(input int max_cyc, input bit hold);
        int n = 0;
        while ((rdy_q.size() != 0 || done_q.size() != 0) && n < max_cyc) begin
            sync();
            n++;
            if (!hold) begin
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        req_valid[i] = 1'b0;
                        req_mode[2*i +: 2] = ~req_mode[2*i +: 2];
                    end
                end
            end
        end
        if (rdy_q.size() != 0 || done_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL service_timeout: got %0d pending expected 0 (cycle %0d)",
                     rdy_q.size() + done_q.size(), cyc);
            rdy_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int s;
        mode_t cur;
        mode_t m;
        int lat;
        sched_state_t exp_st [6];
        mode_t        exp_cm [6];

        exp_st = '{ST_GRANT, ST_SETTLE, ST_SETTLE, ST_SETTLE, ST_FLUSH, ST_DONE};
        exp_cm = '{MODE_IDLE, MODE_IDLE, MODE_IDLE, MODE_IDLE, MODE_FLUSH, MODE_IDLE};

        // Single-requester vectors from reset: change = 2+S, same mode = 2, flush = 3+S.
        vecs[0] = '{id: 0, mode: MODE_RUN,   lat: 5, fin: MODE_RUN};
        vecs[1] = '{id: 3, mode: MODE_RUN,   lat: 2, fin: MODE_RUN};
        vecs[2] = '{id: 1, mode: MODE_HOLD,  lat: 5, fin: MODE_HOLD};
        vecs[3] = '{id: 2, mode: MODE_FLUSH, lat: 6, fin: MODE_IDLE};
        vecs[4] = '{id: 2, mode: MODE_IDLE,  lat: 2, fin: MODE_IDLE};
        vecs[5] = '{id: 1, mode: MODE_RUN,   lat: 5, fin: MODE_RUN};
        vecs[6] = '{id: 0, mode: MODE_FLUSH, lat: 6, fin: MODE_IDLE};

        req_valid = '0;
        req_mode  = '0;
        rst       = 1'b1;

        sync();
        chk("rst_state", 32'(state_o), 32'(ST_IDLE));
        chk("rst_cur_mode", 32'(cur_mode), 32'(MODE_IDLE));
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        sync();

        foreach (vecs[v]) begin
            t = cyc;
            drive(vecs[v].id, vecs[v].mode);
            push(t + 1, vecs[v].id, MODE_IDLE, 1'b0);
            push(t + vecs[v].lat, vecs[v].id, vecs[v].fin, 1'b1);
            service(30, 1'b0);
            sync();
            chk("vec_back_to_idle", 32'(state_o), 32'(ST_IDLE));
            chk("vec_idle_not_busy", 32'(busy), 32'd0);
        end

        // Two simultaneous requesters: 0 wins first, 2 follows after the idle cycle.
        do_reset();
        t = cyc;
        drive(0, MODE_RUN);
        drive(2, MODE_HOLD);
        push(t + 1, 0, MODE_IDLE, 1'b0);
        push(t + 5, 0, MODE_RUN, 1'b1);
        push(t + 7, 2, MODE_IDLE, 1'b0);
        push(t + 11, 2, MODE_HOLD, 1'b1);
        service(40, 1'b0);

        // All requesters held valid: grants must rotate without skipping anyone.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, (i % 2 == 0) ? MODE_RUN : MODE_HOLD);
        s = cyc;
        cur = MODE_IDLE;
        for (int k = 0; k < 20; k++) begin
            m = ((k % N) % 2 == 0) ? MODE_RUN : MODE_HOLD;
            lat = (m == cur) ? 2 : ((m == MODE_FLUSH) ? 3 + S : 2 + S);
            push(s + 1, k % N, MODE_IDLE, 1'b0);
            push(s + lat, k % N, m, 1'b1);
            cur = m;
            s = s + lat + 1;
        end
        service(250, 1'b1);
        req_valid = '0;
        sync();
        sync();
        chk("rotate_idle", 32'(state_o), 32'(ST_IDLE));

        // Flush: walk the state and mode trace cycle by cycle.
        do_reset();
        t = cyc;
        drive(1, MODE_FLUSH);
        push(t + 1, 1, MODE_IDLE, 1'b0);
        push(t + 6, 1, MODE_IDLE, 1'b1);
        for (int j = 0; j < 6; j++) begin
            sync();
            if (j == 0) req_valid[1] = 1'b0;
            chk("flush_state", 32'(state_o), 32'(exp_st[j]));
            chk("flush_cur_mode", 32'(cur_mode), 32'(exp_cm[j]));
            chk("flush_busy", 32'(busy), 32'd1);
        end
        sync();
        chk("flush_back_idle", 32'(state_o), 32'(ST_IDLE));
        chk("flush_sb_empty", 32'(rdy_q.size() + done_q.size()), 32'd0);

        // Reset in the second settle cycle of a HOLD request aborts it with no done.
        do_reset();
        t = cyc;
        drive(2, MODE_HOLD);
        push(t + 1, 2, MODE_IDLE, 1'b0);
        sync();
        req_valid[2] = 1'b0;
        sync();
        chk("abort_settle1", 32'(state_o), 32'(ST_SETTLE));
        sync();
        chk("abort_settle2", 32'(state_o), 32'(ST_SETTLE));
        rst = 1'b1;
        #1;
        chk("abort_state", 32'(state_o), 32'(ST_IDLE));
        chk("abort_cur_mode", 32'(cur_mode), 32'(MODE_IDLE));
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        sync();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) sync();
        chk("abort_no_pending", 32'(rdy_q.size() + done_q.size()), 32'd0);
        t = cyc;
        drive(0, MODE_RUN);
        drive(2, MODE_HOLD);
        push(t + 1, 0, MODE_IDLE, 1'b0);
        push(t + 5, 0, MODE_RUN, 1'b1);
        push(t + 7, 2, MODE_IDLE, 1'b0);
        push(t + 11, 2, MODE_HOLD, 1'b1);
        service(40, 1'b0);
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
